// File: rtl/wbs_uart_tx.sv
// wbs_uart_tx: Wishbone B4 pipelined slave feeding a TX FIFO
// into an 8N1 UART serialiser with a programmable baud divisor.
module wbs_uart_tx #(
    parameter int CLK_HZ     = 48_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_stall_o,
    output logic        wbs_ack_o,
    output logic        uart_tx_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0]   DIV_RST  = 16'(CLK_HZ / BAUD);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [15:0] div_q;
    logic [15:0] div_eff;
    logic        accept;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] rdata;
    logic [7:0]  lvl8;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] timer_q;
    logic [15:0] timer_d;
    logic [15:0] period_q;
    logic [15:0] period_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        tx_d;
    logic        busy;
    logic        unused_ok;

    assign fifo_full   = level == LVL_FULL;
    assign fifo_empty  = level == '0;
    assign wbs_stall_o = wbs_cyc_i & wbs_stb_i & wbs_we_i
                       & (wbs_adr_i == 4'h0) & fifo_full;
    assign accept      = wbs_cyc_i & wbs_stb_i & ~wbs_stall_o;
    assign wr_req      = accept & wbs_we_i;
    assign rd_req      = accept & ~wbs_we_i;
    assign push        = wr_req & (wbs_adr_i == 4'h0) & wbs_sel_i[0];
    assign busy        = state_q != IDLE;
    assign lvl8        = 8'(level);
    assign div_eff     = (div_q == '0) ? 16'd1 : div_q;
    assign unused_ok   = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (wbs_adr_i == 4'h1):
                rdata = {16'h0, lvl8, 5'h0, busy, fifo_empty, fifo_full};
            (wbs_adr_i == 4'h2):
                rdata = {16'h0, div_q};
            default:
                rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            div_q     <= DIV_RST;
        end else begin
            wbs_ack_o <= accept;
            if (rd_req) begin
                wbs_dat_o <= rdata;
            end else if (wr_req) begin
                wbs_dat_o <= '0;
            end
            if (wr_req && wbs_adr_i == 4'h2) begin
                if (wbs_sel_i[0]) div_q[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) div_q[15:8] <= wbs_dat_i[15:8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= wbs_dat_i[7:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Divisor is latched per frame so a DIV write never stretches a live bit
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        period_d = period_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        tx_d     = 1'b1;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = mem[rd_ptr];
                    period_d = div_eff;
                    timer_d  = div_eff - 16'd1;
                    state_d  = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (timer_q == '0) begin
                    timer_d = period_q - 16'd1;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (timer_q == '0) begin
                    timer_d = period_q - 16'd1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (timer_q == '0) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = mem[rd_ptr];
                        period_d = div_eff;
                        timer_d  = div_eff - 16'd1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            period_q  <= 16'd1;
            bit_q     <= '0;
            shift_q   <= '0;
            uart_tx_o <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            uart_tx_o <= tx_d;
        end
    end

endmodule
